// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing the single-port result/config SRAM
// between the Avalon bus slave and the calculation engine, one word per access.
module mem_arbiter #(
  parameter int                ADDR_W  = 11,
  parameter int                DATA_W  = 16,
  parameter logic [ADDR_W-1:0] MAXADDR = 11'h62C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic              bus_gnt,
  output logic              bus_done,
  output logic              bus_err,
  output logic [DATA_W-1:0] bus_rdata,
  input  logic              eng_req,
  input  logic              eng_we,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_wdata,
  output logic              eng_gnt,
  output logic              eng_done,
  output logic              eng_err,
  output logic [DATA_W-1:0] eng_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_BUS, OWN_ENG} owner_t;

  state_t            state;
  owner_t            owner;
  owner_t            last_owner;
  logic              cur_we;
  logic              cur_err;
  logic              pick_eng;
  logic              sel_we;
  logic              sel_oor;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // The engine wins when it is alone, or when both ask and the bus went last.
  assign pick_eng  = eng_req && (!bus_req || last_owner == OWN_BUS);
  assign sel_we    = pick_eng ? eng_we    : bus_we;
  assign sel_addr  = pick_eng ? eng_addr  : bus_addr;
  assign sel_wdata = pick_eng ? eng_wdata : bus_wdata;
  assign sel_oor   = sel_addr > MAXADDR;
  assign busy      = state != IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_BUS;
      last_owner <= OWN_ENG;
      cur_we     <= 1'b0;
      cur_err    <= 1'b0;
      bus_gnt    <= 1'b0;
      bus_done   <= 1'b0;
      bus_err    <= 1'b0;
      bus_rdata  <= '0;
      eng_gnt    <= 1'b0;
      eng_done   <= 1'b0;
      eng_err    <= 1'b0;
      eng_rdata  <= '0;
      mem_addr   <= '0;
      mem_ren    <= 1'b0;
      mem_wen    <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      bus_done <= 1'b0;
      bus_err  <= 1'b0;
      eng_done <= 1'b0;
      eng_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus_req || eng_req) begin
            owner      <= pick_eng ? OWN_ENG : OWN_BUS;
            last_owner <= pick_eng ? OWN_ENG : OWN_BUS;
            cur_we     <= sel_we;
            cur_err    <= sel_oor;
            bus_gnt    <= !pick_eng;
            eng_gnt    <= pick_eng;
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
            mem_ren    <= !sel_we && !sel_oor;
            mem_wen    <= sel_we && !sel_oor;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          bus_gnt   <= 1'b0;
          eng_gnt   <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          mem_ren   <= 1'b0;
          mem_wen   <= 1'b0;
          state     <= RESP;
        end
        RESP: begin
          // SRAM read data is valid now; capture it alongside the completion flags.
          if (owner == OWN_BUS) begin
            bus_done <= 1'b1;
            bus_err  <= cur_err;
            if (!cur_we && !cur_err) bus_rdata <= mem_rdata;
          end else begin
            eng_done <= 1'b1;
            eng_err  <= cur_err;
            if (!cur_we && !cur_err) eng_rdata <= mem_rdata;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand-written contention, reset
// and back-to-back sequences against a behavioural registered-read SRAM.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_req, bus_we, eng_req, eng_we;
  logic [10:0] bus_addr, eng_addr;
  logic [15:0] bus_wdata, eng_wdata;
  logic        bus_gnt, bus_done, bus_err, eng_gnt, eng_done, eng_err;
  logic [15:0] bus_rdata, eng_rdata;
  logic [10:0] mem_addr;
  logic        mem_ren, mem_wen, busy;
  logic [15:0] mem_wdata, mem_rdata;

  logic [15:0] sram [0:2047];
  logic        preload_done = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        eng;
    logic        we;
    logic [10:0] addr;
    logic [15:0] wdata;
    logic        exp_err;
    logic [15:0] exp_rdata;
    logic [15:0] exp_other;
  } vec_t;

  vec_t vecs [10];

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_done(bus_done), .bus_err(bus_err), .bus_rdata(bus_rdata),
    .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_gnt(eng_gnt), .eng_done(eng_done), .eng_err(eng_err), .eng_rdata(eng_rdata),
    .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered-read SRAM, preloaded once on the first clock edge.
  always @(posedge clk) begin
    if (!preload_done) begin
      for (int a = 0; a < 2048; a++) sram[a] <= 16'h0000;
      sram[11'h010] <= 16'hBEEF;
      sram[11'h62D] <= 16'h5555;
      sram[11'h7FF] <= 16'hAAAA;
      mem_rdata     <= 16'h0000;
      preload_done  <= 1'b1;
    end else begin
      if (mem_wen) sram[mem_addr] <= mem_wdata;
      if (mem_ren) mem_rdata <= sram[mem_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int          gnt_cyc, done_cyc, strobe_cyc, ren_cnt, wen_cnt, other_act, stray_err;
    logic        err_seen, busy_at_gnt;
    logic [15:0] rd_seen;
    gnt_cyc = -1; done_cyc = -1; strobe_cyc = -1;
    ren_cnt = 0; wen_cnt = 0; other_act = 0; stray_err = 0;
    err_seen = 1'bx; busy_at_gnt = 1'b0; rd_seen = 16'hDEAD;
    if (v.eng) begin
      eng_req = 1'b1; eng_we = v.we; eng_addr = v.addr; eng_wdata = v.wdata;
    end else begin
      bus_req = 1'b1; bus_we = v.we; bus_addr = v.addr; bus_wdata = v.wdata;
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (v.eng ? eng_gnt : bus_gnt) begin
        if (gnt_cyc < 0) gnt_cyc = c;
        busy_at_gnt = busy;
        if (v.eng) eng_req = 1'b0; else bus_req = 1'b0;
      end
      if (mem_ren) begin ren_cnt++; strobe_cyc = c; end
      if (mem_wen) begin wen_cnt++; strobe_cyc = c; end
      if (v.eng ? eng_done : bus_done) begin
        done_cyc = c;
        err_seen = v.eng ? eng_err : bus_err;
        rd_seen  = v.eng ? eng_rdata : bus_rdata;
      end
      if ((v.eng ? eng_err : bus_err) && !(v.eng ? eng_done : bus_done)) stray_err++;
      if (v.eng ? (bus_gnt || bus_done || bus_err) : (eng_gnt || eng_done || eng_err)) other_act++;
    end
    checkOutput({v.tag, "_gnt_lat"},   gnt_cyc, 1);
    checkOutput({v.tag, "_busy"},      busy_at_gnt, 1'b1);
    checkOutput({v.tag, "_done_lat"},  done_cyc, 3);
    checkOutput({v.tag, "_err"},       err_seen, v.exp_err);
    checkOutput({v.tag, "_stray_err"}, stray_err, 0);
    checkOutput({v.tag, "_ren_cnt"},   ren_cnt, (!v.we && !v.exp_err) ? 1 : 0);
    checkOutput({v.tag, "_wen_cnt"},   wen_cnt, (v.we && !v.exp_err) ? 1 : 0);
    checkOutput({v.tag, "_strobe_cyc"}, strobe_cyc, v.exp_err ? -1 : 1);
    checkOutput({v.tag, "_rdata"},     rd_seen, v.exp_rdata);
    checkOutput({v.tag, "_other_rd"},  v.eng ? bus_rdata : eng_rdata, v.exp_other);
    checkOutput({v.tag, "_other_act"}, other_act, 0);
  endtask

  task automatic contend(input logic [10:0] b_addr, input logic [10:0] e_addr,
                         output int b_gnt, output int e_gnt, output int both_gnt);
    b_gnt = -1; e_gnt = -1; both_gnt = 0;
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = b_addr;
    eng_req = 1'b1; eng_we = 1'b0; eng_addr = e_addr;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus_gnt && eng_gnt) both_gnt++;
      if (bus_gnt) begin if (b_gnt < 0) b_gnt = c; bus_req = 1'b0; end
      if (eng_gnt) begin if (e_gnt < 0) e_gnt = c; eng_req = 1'b0; end
    end
    bus_req = 1'b0; eng_req = 1'b0;
  endtask

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int          bg, eg, both, dn_cnt, n_gnt, n_done;
    int          gnt_c [3];
    int          done_c [3];
    logic [15:0] rd_c [3];
    vec_t        single;

    vecs[0] = '{"bus_rd_010",  1'b0, 1'b0, 11'h010, 16'h0000, 1'b0, 16'hBEEF, 16'h0000};
    vecs[1] = '{"eng_wr_max",  1'b1, 1'b1, 11'h62C, 16'h1234, 1'b0, 16'h0000, 16'hBEEF};
    vecs[2] = '{"bus_rd_max",  1'b0, 1'b0, 11'h62C, 16'h0000, 1'b0, 16'h1234, 16'h0000};
    vecs[3] = '{"bus_rd_oor",  1'b0, 1'b0, 11'h62D, 16'h0000, 1'b1, 16'h1234, 16'h0000};
    vecs[4] = '{"eng_wr_oor",  1'b1, 1'b1, 11'h7FF, 16'hFFFF, 1'b1, 16'h0000, 16'h1234};
    vecs[5] = '{"eng_rd_010",  1'b1, 1'b0, 11'h010, 16'h0000, 1'b0, 16'hBEEF, 16'h1234};
    vecs[6] = '{"eng_rd_oor",  1'b1, 1'b0, 11'h7FF, 16'h0000, 1'b1, 16'hBEEF, 16'h1234};
    vecs[7] = '{"bus_wr_000",  1'b0, 1'b1, 11'h000, 16'h00A5, 1'b0, 16'h1234, 16'hBEEF};
    vecs[8] = '{"bus_rd_000",  1'b0, 1'b0, 11'h000, 16'h0000, 1'b0, 16'h00A5, 16'hBEEF};
    vecs[9] = '{"eng_rd_max",  1'b1, 1'b0, 11'h62C, 16'h0000, 1'b0, 16'h1234, 16'h00A5};

    rst = 1'b1;
    bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    eng_req = 1'b0; eng_we = 1'b0; eng_addr = '0; eng_wdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ctrl", {bus_gnt, bus_done, bus_err, eng_gnt, eng_done, eng_err,
                               mem_ren, mem_wen, busy}, 0);
    checkOutput("reset_data", {bus_rdata, eng_rdata, mem_addr, mem_wdata}, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", busy, 1'b0);

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);
    checkOutput("sram_oor_untouched", sram[11'h7FF], 16'hAAAA);
    checkOutput("sram_max_written",   sram[11'h62C], 16'h1234);

    // Contention from reset: bus first, engine three cycles later.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    contend(11'h010, 11'h62C, bg, eg, both);
    checkOutput("contA_bus_gnt", bg, 1);
    checkOutput("contA_eng_gnt", eg, 4);
    checkOutput("contA_overlap", both, 0);
    checkOutput("contA_bus_rd",  bus_rdata, 16'hBEEF);
    checkOutput("contA_eng_rd",  eng_rdata, 16'h1234);

    // A lone bus access leaves the bus as last owner, so the engine wins next.
    single = '{"bus_rd_solo", 1'b0, 1'b0, 11'h000, 16'h0000, 1'b0, 16'h00A5, 16'h1234};
    applyStimulus(single);
    contend(11'h62C, 11'h000, bg, eg, both);
    checkOutput("contB_eng_gnt", eg, 1);
    checkOutput("contB_bus_gnt", bg, 4);
    checkOutput("contB_overlap", both, 0);
    checkOutput("contB_bus_rd",  bus_rdata, 16'h1234);
    checkOutput("contB_eng_rd",  eng_rdata, 16'h00A5);

    // Reset during RESP of a bus read.
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 11'h010;
    @(negedge clk);
    checkOutput("midrst_gnt", bus_gnt, 1'b1);
    bus_req = 1'b0;
    @(negedge clk);
    checkOutput("midrst_in_resp", busy, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_async_ctrl", {bus_gnt, bus_done, bus_err, eng_gnt, eng_done, eng_err,
                                      mem_ren, mem_wen, busy}, 0);
    checkOutput("midrst_async_data", {bus_rdata, eng_rdata, mem_addr, mem_wdata}, 0);
    @(negedge clk);
    rst = 1'b0;
    dn_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus_done || busy) dn_cnt++;
    end
    checkOutput("midrst_no_done", dn_cnt, 0);
    checkOutput("midrst_rdata",   bus_rdata, 16'h0000);
    contend(11'h010, 11'h010, bg, eg, both);
    checkOutput("midrst_bus_first", bg, 1);
    checkOutput("midrst_eng_next",  eg, 4);

    // Bus request held high across three back-to-back reads.
    n_gnt = 0; n_done = 0;
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 11'h010;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (bus_gnt) begin
        if (n_gnt < 3) gnt_c[n_gnt] = c;
        n_gnt++;
        if (n_gnt == 1) bus_addr = 11'h62C;
        else if (n_gnt == 2) bus_addr = 11'h000;
        else bus_req = 1'b0;
      end
      if (bus_done) begin
        if (n_done < 3) begin done_c[n_done] = c; rd_c[n_done] = bus_rdata; end
        n_done++;
      end
    end
    bus_req = 1'b0;
    checkOutput("held_gnt_cnt",  n_gnt, 3);
    checkOutput("held_done_cnt", n_done, 3);
    checkOutput("held_gnt0",  gnt_c[0], 1);
    checkOutput("held_gnt1",  gnt_c[1], 4);
    checkOutput("held_gnt2",  gnt_c[2], 7);
    checkOutput("held_done0", done_c[0], 3);
    checkOutput("held_done2", done_c[2], 9);
    checkOutput("held_rd0",   rd_c[0], 16'hBEEF);
    checkOutput("held_rd1",   rd_c[1], 16'h1234);
    checkOutput("held_rd2",   rd_c[2], 16'h00A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the single-port result/config SRAM (11-bit word address, 16-bit data). It shares the SRAM between the Avalon slave controller (bus side) and the calculation engine (engine side). Each request is a single-word read or write. Winners are chosen round-robin, and the arbiter returns a completion pulse, read data and an address-range error to the owning requester.

## Interface
Parameters:
- ADDR_W, 11, SRAM word-address width
- DATA_W, 16, SRAM data width
- MAXADDR, 11'h62C, highest legal address (inclusive)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset; single clock domain
- bus_req  in  1  bus-side access request, held until bus_gnt
- bus_we  in  1  1 = write, 0 = read; stable while bus_req high
- bus_addr  in  ADDR_W  word address
- bus_wdata  in  DATA_W  write data
- bus_gnt  out  1  one-cycle pulse: request accepted, memory strobes driven
- bus_done  out  1  one-cycle completion pulse
- bus_err  out  1  valid with bus_done: address > MAXADDR
- bus_rdata  out  DATA_W  read result, held until the next bus read completes
- eng_req, eng_we, eng_addr, eng_wdata, eng_gnt, eng_done, eng_err, eng_rdata: same directions, widths and meanings for the engine side
- mem_addr  out  ADDR_W  SRAM address
- mem_ren  out  1  SRAM read strobe; data appears on mem_rdata the next cycle
- mem_wen  out  1  SRAM write strobe
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, choose a winner, latch owner, we, addr and wdata, then go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - A single requester wins outright.
  - When both request, the side that is not last_owner wins.
  - last_owner updates on every grant, including error grants.
  - last_owner reset value is ENG, so the bus wins the first contested grant.
- ACCESS (1 cycle):
  - Pulse the owner's gnt.
  - Drive mem_addr and mem_wdata from the latched values.
  - Assert mem_ren (read) or mem_wen (write) only if addr <= MAXADDR.
  - Out-of-range: no strobe; set the err flag.
  - Always go to RESP.
- RESP (1 cycle):
  - Reads: mem_rdata is valid this cycle and is captured into the owner's rdata register at the closing edge, unless the access was an error.
  - The owner's done and err are registered at the same edge.
  - Go to IDLE.
- Completion: done/err are high for exactly one cycle, the first IDLE cycle after RESP. err is 0 whenever done is 0.
- Requester rule: drop req in the cycle after gnt. A req still high at the end of the done cycle is treated as a new request.
- The non-owner's outputs (gnt, done, err, rdata) do not change during another side's access.
- mem_addr, mem_wdata, mem_ren and mem_wen are 0 outside ACCESS.
- Address compare is unsigned over the full ADDR_W bits.
- Reset values: state IDLE, last_owner ENG. All gnt/done/err/mem_* outputs, busy and both rdata registers are 0.
- Reset mid-operation aborts the access: no done pulse, rdata keeps its reset value 0.

## Timing
- Req high before edge E0 in IDLE: ACCESS in cycle E0–E1, RESP in E1–E2, done in E2–E3.
- Gnt latency: 1 cycle. Done latency: 3 cycles after the first sampled req.
- Throughput: one access per 3 cycles. A pending loser is sampled at the end of the done cycle, so its gnt comes 1 cycle after the winner's done.
- Simultaneous req in IDLE: exactly one gnt. The loser keeps req high and is granted next, so no side waits more than one foreign access.
- Read data lands on rdata in the same cycle done rises.
- Write data is in the SRAM after the ACCESS edge; done is informational only.

## Test plan
- Bus read after reset: preload SRAM[0x010]=0xBEEF; bus_req=1, bus_we=0, bus_addr=0x010. Expect bus_gnt 1 cycle later, mem_ren in the same cycle, then bus_done=1, bus_err=0, bus_rdata=0xBEEF 2 cycles after gnt. eng_* outputs stay 0.
- Engine write then bus read: eng writes 0x1234 to 0x62C (MAXADDR, boundary legal); bus then reads 0x62C. Expect mem_wen once, then bus_rdata=0x1234 with err=0.
- Out of range: bus read at 0x62D, then eng write at 0x7FF. Each gets gnt and done with err=1, and mem_ren/mem_wen never assert. bus_rdata keeps its prior value.
- Contention: both req high on the same cycle from reset. Expect bus_gnt first, eng_gnt 3 cycles later. Then both request again: eng wins this time (alternation).
- Reset mid-op: assert rst during RESP of a bus read. Expect all outputs 0 immediately (asynchronous), no bus_done after release, busy=0, and the next contested grant goes to the bus.
- Held request: keep bus_req high continuously for 3 reads. Expect a gnt every 3 cycles and 3 done pulses with correct data.
